// File: rtl/alu_ctrl_issue.sv
// ALU control decoder feeding a 2-entry issue FIFO with valid/ready handshakes on both sides.
// Optional saturating illegal-entry counter enabled by defining ALU_CTRL_ILLEGAL_CNT_EN.
module alu_ctrl_issue (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_ctrl,
    output logic       out_illegal,
    output logic [7:0] illegal_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       illegal;
    } entry_t;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_SLL = 4'b1001;
    localparam logic [3:0] CTRL_SRL = 4'b1010;
    localparam logic [3:0] CTRL_SRA = 4'b1011;
    localparam logic [3:0] CTRL_XOR = 4'b1100;
    localparam logic [3:0] CTRL_ILL = 4'b1111;

    function automatic entry_t decode(input logic [1:0] op, input logic [2:0] f3,
                                      input logic f7);
        entry_t e;
        e.ctrl    = CTRL_ADD;
        e.illegal = 1'b0;
        case (op)
            2'b00: e.ctrl = CTRL_ADD;
            2'b01: e.ctrl = CTRL_SUB;
            default: begin
                case (f3)
                    3'b000: e.ctrl = (op == 2'b10 && f7) ? CTRL_SUB : CTRL_ADD;
                    3'b001: begin
                        // Shift-immediate with bit 30 set has no legal encoding.
                        if (op == 2'b11 && f7) e.illegal = 1'b1;
                        else                   e.ctrl    = CTRL_SLL;
                    end
                    3'b010: e.ctrl = CTRL_SLT;
                    3'b011: e.illegal = 1'b1;
                    3'b100: e.ctrl = CTRL_XOR;
                    3'b101: e.ctrl = f7 ? CTRL_SRA : CTRL_SRL;
                    3'b110: e.ctrl = CTRL_OR;
                    default: e.ctrl = CTRL_AND;
                endcase
            end
        endcase
        if (e.illegal) e.ctrl = CTRL_ILL;
        return e;
    endfunction

    state_t state, state_nxt;
    entry_t head, tail, new_entry;
    logic   push, pop;
    logic   load_head_new, load_head_tail, load_tail;

    assign new_entry = decode(alu_op, funct3, funct7b5);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    always_comb begin
        state_nxt      = state;
        in_ready       = 1'b1;
        out_valid      = 1'b0;
        load_head_new  = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        case (state)
            ONE: out_valid = 1'b1;
            TWO: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
            end
            default: ;
        endcase
        push = in_valid && in_ready;
        pop  = out_valid && out_ready;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt     = ONE;
                    load_head_new = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head_new = 1'b1;
                end else if (push) begin
                    state_nxt = TWO;
                    load_tail = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nxt      = ONE;
                    load_head_tail = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // NOTE: the head register is reset because its value is visible on out_ctrl after reset;
    // the tail is reset only to keep the two slots symmetric.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load_head_new)       head <= new_entry;
            else if (load_head_tail) head <= tail;
            if (load_tail)           tail <= new_entry;
        end
    end

    assign out_ctrl    = head.ctrl;
    assign out_illegal = head.illegal;

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (push && new_entry.illegal && cnt != 8'hFF)
            cnt <= cnt + 8'd1;
    end

    assign illegal_cnt = cnt;
`else
    assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed self-checking bench for alu_ctrl_issue; expected counter values follow
// whether ALU_CTRL_ILLEGAL_CNT_EN is defined for the build.
module tb_alu_ctrl_issue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_ctrl;
    logic       out_illegal;
    logic [7:0] illegal_cnt;

    int checks = 0;
    int errors = 0;

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    alu_ctrl_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                         input logic f7);
        in_valid = v;
        alu_op   = op;
        funct3   = f3;
        funct7b5 = f7;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] ctrl;
        logic       ill;
    } vec_t;

    vec_t vecs[8] = '{
        '{2'b00, 3'b111, 1'b1, 4'b0010, 1'b0},
        '{2'b01, 3'b000, 1'b0, 4'b0110, 1'b0},
        '{2'b11, 3'b000, 1'b1, 4'b0010, 1'b0},
        '{2'b10, 3'b101, 1'b0, 4'b1010, 1'b0},
        '{2'b10, 3'b001, 1'b1, 4'b1001, 1'b0},
        '{2'b11, 3'b010, 1'b0, 4'b0111, 1'b0},
        '{2'b10, 3'b011, 1'b0, 4'b1111, 1'b1},
        '{2'b11, 3'b110, 1'b0, 4'b0001, 1'b0}
    };

    int ill_pushed;

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 2'b00, 3'b000, 1'b0);
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, 4'b0000);
        check("rst_out_illegal", out_illegal, 0);
        check("rst_cnt", illegal_cnt, 0);

        // R-type SUB, consumed immediately
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 2'b10, 3'b000, 1'b1);
        tick();
        check("sub_valid", out_valid, 1);
        check("sub_ctrl", out_ctrl, 4'b0110);
        drive(1'b0, 2'b10, 3'b000, 1'b1);
        tick();
        check("sub_empty_valid", out_valid, 0);
        check("sub_empty_ready", in_ready, 1);

        // Backpressure: AND, OR fill the FIFO, XOR is held off
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 3'b111, 1'b0);
        tick();
        check("bp1_ctrl", out_ctrl, 4'b0000);
        check("bp1_ready", in_ready, 1);
        drive(1'b1, 2'b10, 3'b110, 1'b0);
        tick();
        check("bp2_ctrl", out_ctrl, 4'b0000);
        check("bp2_ready", in_ready, 0);
        drive(1'b1, 2'b10, 3'b100, 1'b0);
        tick();
        check("bp3_ctrl", out_ctrl, 4'b0000);
        check("bp3_ready", in_ready, 0);
        check("bp3_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check("rel1_ctrl", out_ctrl, 4'b0001);
        check("rel1_ready", in_ready, 1);
        tick();
        check("rel2_ctrl", out_ctrl, 4'b1100);
        check("rel2_valid", out_valid, 1);
        drive(1'b0, 2'b00, 3'b000, 1'b0);
        tick();
        check("rel3_valid", out_valid, 0);

        // I-type SRA held, then illegal shift pushed while popping
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 3'b101, 1'b1);
        tick();
        check("sra_ctrl", out_ctrl, 4'b1011);
        check("sra_ill", out_illegal, 0);
        out_ready = 1'b1;
        drive(1'b1, 2'b11, 3'b001, 1'b1);
        tick();
        check("ishl_ctrl", out_ctrl, 4'b1111);
        check("ishl_ill", out_illegal, 1);
        check("ishl_cnt", illegal_cnt, CNT_EN ? 1 : 0);

        // Simultaneous push SLT + pop in ONE
        drive(1'b1, 2'b10, 3'b010, 1'b0);
        tick();
        check("slt_ctrl", out_ctrl, 4'b0111);
        check("slt_valid", out_valid, 1);
        check("slt_ready", in_ready, 1);
        check("slt_ill", out_illegal, 0);

        // Streaming decode table
        ill_pushed = 1;
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].f3, vecs[i].f7);
            tick();
            check($sformatf("vec%0d_ctrl", i), out_ctrl, vecs[i].ctrl);
            check($sformatf("vec%0d_ill", i), out_illegal, vecs[i].ill);
            if (vecs[i].ill) ill_pushed++;
        end
        check("tbl_cnt", illegal_cnt, CNT_EN ? ill_pushed : 0);

        // Counter saturation
        for (int k = 0; k < 260; k++) begin
            drive(1'b1, 2'b10, 3'b011, 1'b0);
            tick();
        end
        check("sat_cnt", illegal_cnt, CNT_EN ? 255 : 0);
        check("sat_ctrl", out_ctrl, 4'b1111);

        // Reset while full; in_valid held high during reset must not push
        drive(1'b0, 2'b00, 3'b000, 1'b0);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 3'b100, 1'b0);
        tick();
        tick();
        check("full_ready", in_ready, 0);
        rst_n = 1'b0;
        tick();
        check("mrst_valid", out_valid, 0);
        check("mrst_ready", in_ready, 1);
        check("mrst_ctrl", out_ctrl, 4'b0000);
        check("mrst_cnt", illegal_cnt, 0);
        rst_n = 1'b1;
        drive(1'b0, 2'b00, 3'b000, 1'b0);
        tick();
        check("post_rst_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
